// File: rtl/wptr_full_ctrl_if.sv
// Write-side handshake bundle between the async-FIFO producer and wptr_full_ctrl.
// master drives the write request and synchronized read pointer; slave is the controller.
interface wptr_full_ctrl_if #(parameter int ADDRSIZE = 9);
  logic                winc;
  logic [ADDRSIZE:0]   rptr_sync;
  logic                wen;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wbin;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  modport master (
    output winc, rptr_sync,
    input  wen, waddr, wbin, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, rptr_sync,
    output wen, waddr, wbin, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Async-FIFO write pointer / full-flag generator (write clock domain only).
// Define WPTR_LEVEL_EN to build the occupancy level and almost-full registers.
module wptr_full_ctrl #(
  parameter int ADDRSIZE     = 9,
  parameter int AFULL_THRESH = 480
) (
  input  logic            wclk,
  input  logic            w_rst_n,
  wptr_full_ctrl_if.slave wif
);

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic              wfull_q, wfull_d;
  logic              woverflow_q, woverflow_d;
  logic              accept;
  logic [ADDRSIZE:0] rptr_full_cmp;

  always_comb begin
    accept        = wif.winc & ~wfull_q;
    wbin_d        = wbin_q + {{ADDRSIZE{1'b0}}, accept};
    wptr_d        = (wbin_d >> 1) ^ wbin_d;
    // Full when the write pointer is exactly one lap ahead of the read pointer in Gray space
    rptr_full_cmp = {~wif.rptr_sync[ADDRSIZE:ADDRSIZE-1], wif.rptr_sync[ADDRSIZE-2:0]};
    wfull_d       = (wptr_d == rptr_full_cmp);
    woverflow_d   = woverflow_q | (wif.winc & wfull_q);
  end

  always_ff @(posedge wclk) begin
    if (!w_rst_n) begin
      wbin_q      <= '0;
      wptr_q      <= '0;
      wfull_q     <= 1'b0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wptr_q      <= wptr_d;
      wfull_q     <= wfull_d;
      woverflow_q <= woverflow_d;
    end
  end

  // Gate with reset so a stale full flag or winc cannot write memory during reset
  assign wif.wen       = accept & w_rst_n;
  assign wif.waddr     = wbin_q[ADDRSIZE-1:0];
  assign wif.wbin      = wbin_q;
  assign wif.wptr      = wptr_q;
  assign wif.wfull     = wfull_q;
  assign wif.woverflow = woverflow_q;

`ifdef WPTR_LEVEL_EN
  localparam logic [ADDRSIZE:0] AF_TH = (ADDRSIZE+1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] rbin_sync;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              afull_q, afull_d;
  logic              acc;

  always_comb begin
    rbin_sync = '0;
    acc       = 1'b0;
    for (int i = ADDRSIZE; i >= 0; i--) begin
      acc          = acc ^ wif.rptr_sync[i];
      rbin_sync[i] = acc;
    end
    // Lagging rptr_sync makes this an over-estimate, never an under-estimate
    wlevel_d = wbin_d - rbin_sync;
    afull_d  = (wlevel_d >= AF_TH);
  end

  always_ff @(posedge wclk) begin
    if (!w_rst_n) begin
      wlevel_q <= '0;
      afull_q  <= 1'b0;
    end else begin
      wlevel_q <= wlevel_d;
      afull_q  <= afull_d;
    end
  end

  assign wif.wlevel       = wlevel_q;
  assign wif.walmost_full = afull_q;
`else
  assign wif.wlevel       = '0;
  assign wif.walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl: driver models occupancy as write/read counts,
// monitor pops expected outputs each cycle and compares.
module tb_wptr_full_ctrl;
  localparam int AS   = 9;
  localparam int DEP  = 512;
  localparam int MOD  = 1024;
  localparam int AFTH = 480;

  logic wclk = 1'b0;
  logic w_rst_n;
  always #5 wclk = ~wclk;

  wptr_full_ctrl_if #(.ADDRSIZE(AS)) wif ();

  wptr_full_ctrl #(.ADDRSIZE(AS), .AFULL_THRESH(AFTH)) dut (
    .wclk    (wclk),
    .w_rst_n (w_rst_n),
    .wif     (wif)
  );

  typedef struct {
    logic          wen;
    logic [AS-1:0] waddr;
    logic [AS:0]   wbin;
    logic [AS:0]   wptr;
    logic          wfull;
    logic          afull;
    logic [AS:0]   wlevel;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model: counts of writes/reads modulo 2*depth
  int m_wr, m_lvl;
  bit m_full, m_ovf;
  bit p_rst, p_winc;
  int p_rd;

  function automatic logic [AS:0] gray(input int v);
    logic [AS:0] b;
    b = v[AS:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit rst, input bit winc, input int rd);
    exp_t e;
    @(posedge wclk);
    if (!p_rst) begin
      m_wr = 0; m_lvl = 0; m_full = 0; m_ovf = 0;
    end else begin
      m_ovf = m_ovf | (p_winc & m_full);
      if (p_winc && !m_full) m_wr = (m_wr + 1) % MOD;
      m_lvl  = ((m_wr - p_rd) % MOD + MOD) % MOD;
      m_full = (m_lvl == DEP);
    end
    #2;
    w_rst_n       = rst;
    wif.winc      = winc;
    wif.rptr_sync = gray(rd);
    p_rst = rst; p_winc = winc; p_rd = rd;
    e.wen   = rst & winc & !m_full;
    e.waddr = m_wr[AS-1:0];
    e.wbin  = m_wr[AS:0];
    e.wptr  = gray(m_wr);
    e.wfull = m_full;
    e.ovf   = m_ovf;
`ifdef WPTR_LEVEL_EN
    e.wlevel = m_lvl[AS:0];
    e.afull  = (m_lvl >= AFTH);
`else
    e.wlevel = '0;
    e.afull  = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  always @(negedge wclk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wen",          32'(wif.wen),          32'(e.wen));
      chk("waddr",        32'(wif.waddr),        32'(e.waddr));
      chk("wbin",         32'(wif.wbin),         32'(e.wbin));
      chk("wptr",         32'(wif.wptr),         32'(e.wptr));
      chk("wfull",        32'(wif.wfull),        32'(e.wfull));
      chk("walmost_full", 32'(wif.walmost_full), 32'(e.afull));
      chk("wlevel",       32'(wif.wlevel),       32'(e.wlevel));
      chk("woverflow",    32'(wif.woverflow),    32'(e.ovf));
    end
  end

  initial begin
    int rd;
    int occ;
    p_rst = 0; p_winc = 0; p_rd = 0;
    m_wr = 0; m_lvl = 0; m_full = 0; m_ovf = 0;
    w_rst_n       = 1'b0;
    wif.winc      = 1'b1;
    wif.rptr_sync = '0;

    // reset held with winc asserted
    step(0, 1, 0);
    step(0, 1, 0);

    // fill from empty, then overflow attempts
    for (int i = 0; i < DEP; i++) step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);

    // release by one read, refill
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 1, 1);
    step(1, 0, 1);
    step(1, 1, 1);

    // random traffic with a lagging read pointer
    rd = 1;
    for (int i = 0; i < 3000; i++) begin
      occ = ((m_wr - rd) % MOD + MOD) % MOD;
      if (occ > 0 && ($urandom_range(0, 99) < 45)) rd = (rd + $urandom_range(1, (occ < 3) ? occ : 3)) % MOD;
      step(1, ($urandom_range(0, 99) < 55), rd);
    end

    // wrap with read pointer trailing
    step(0, 0, 0);
    step(0, 1, 0);
    rd = 0;
    for (int i = 0; i < 2100; i++) begin
      step(1, 1, rd);
      if (i >= 9) rd = (m_wr + MOD - 9) % MOD;
    end

    step(1, 0, rd);
    step(1, 0, rd);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge wclk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
